// File: rtl/overlay_pkg.sv
// Shared types and constants for the overlay prefetch path: the RGBA4444
// pixel layout, the SDRAM fetcher states and the horizontal repeat codes.
package overlay_pkg;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] g;
    logic [3:0] r;
  } ovl_pix_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } fetch_state_e;

  localparam logic [1:0] HSCALE_1X  = 2'd0;
  localparam logic [1:0] HSCALE_2X  = 2'd1;
  localparam logic [1:0] HSCALE_4X  = 2'd2;
  localparam logic [1:0] HSCALE_RSV = 2'd3;

  // Last value of the repeat counter before the head word is popped;
  // the reserved code behaves as 1x.
  function automatic logic [1:0] rep_last(input logic [1:0] hs);
    case (hs)
      HSCALE_2X: return 2'd1;
      HSCALE_4X: return 2'd3;
      default:   return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/ovl_fifo.sv
// Synchronous prefetch FIFO with occupancy count, flush and same-cycle
// push/pop. Callers never push when full nor pop when empty.
module ovl_fifo #(
  parameter int DEPTH = 16,
  parameter int PIX_W = 16
) (
  input  logic                       clk_sys,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [PIX_W-1:0]           push_data,
  input  logic                       pop,
  output logic [PIX_W-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PIX_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Pointer and occupancy bookkeeping; flush empties in a single cycle.
  always_ff @(posedge clk_sys) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Word storage carries no reset; stale entries are never read.
  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/overlay_prefetch.sv
// Streams an RGBA4444 overlay frame from SDRAM through a small FIFO and
// presents one overlay pixel per active video pixel, with 1x/2x/4x
// horizontal pixel repeat and sticky underflow reporting.
module overlay_prefetch
  import overlay_pkg::*;
#(
  parameter int ADDR_W = 25,
  parameter int DEPTH  = 16,
  parameter int PIX_W  = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [1:0]        hscale,
  input  logic              ce_pix,
  input  logic              de,
  input  logic              vsync,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic              mem_ack,
  input  logic [PIX_W-1:0]  mem_data,
  output logic [3:0]        bg_r,
  output logic [3:0]        bg_g,
  output logic [3:0]        bg_b,
  output logic [3:0]        bg_a,
  output logic              underflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] rd_addr;
  logic              discard;
  logic              vsync_q;
  logic [1:0]        rep;
  logic              underflow_r;
  ovl_pix_t          pix_p1;

  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic [PIX_W-1:0]  fifo_head;
  logic              fifo_push, fifo_pop, fifo_flush;

  logic              frame_start, inflight, ack_take, consume, room;
  logic [CW:0]       occupancy;

  assign frame_start = ce_pix & vsync & ~vsync_q;
  assign inflight    = (state != ST_IDLE);
  assign ack_take    = (state == ST_WAIT) & mem_ack;
  assign occupancy   = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
  assign room        = (occupancy < (CW+1)'(DEPTH));

  assign fifo_push   = ack_take & ~discard & ~frame_start & enable;
  assign consume     = ce_pix & de & enable & ~frame_start;
  assign fifo_pop    = consume & ~fifo_empty & (rep == rep_last(hscale));
  assign fifo_flush  = frame_start | ~enable;

  ovl_fifo #(
    .DEPTH (DEPTH),
    .PIX_W (PIX_W)
  ) u_fifo (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (mem_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Fetcher next state: one outstanding read, one-cycle request strobe.
  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    case (state)
      ST_IDLE: if (enable && room) state_nxt = ST_REQ;
      ST_REQ: begin
        mem_rd    = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: if (mem_ack) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign mem_addr = rd_addr;

  // Fetcher state, read address and discard of reads orphaned by frame start.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state   <= ST_IDLE;
      rd_addr <= '0;
      discard <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ce_pix) vsync_q <= vsync;
      if (frame_start) begin
        rd_addr <= base_addr;
        discard <= inflight & ~ack_take;
      end else if (ack_take) begin
        if (discard)     discard <= 1'b0;
        else if (enable) rd_addr <= rd_addr + ADDR_W'(2);
      end
    end
  end

  // Consumer: repeat counter, output pixel register and sticky underflow.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rep         <= 2'd0;
      underflow_r <= 1'b0;
      pix_p1      <= '0;
    end else if (frame_start) begin
      rep         <= 2'd0;
      underflow_r <= 1'b0;
      pix_p1      <= '0;
    end else if (!enable) begin
      rep    <= 2'd0;
      pix_p1 <= '0;
    end else if (ce_pix) begin
      if (de) begin
        if (!fifo_empty) begin
          pix_p1 <= ovl_pix_t'(fifo_head);
          rep    <= (rep == rep_last(hscale)) ? 2'd0 : rep + 2'd1;
        end else begin
          pix_p1      <= '0;
          underflow_r <= 1'b1;
        end
      end else begin
        pix_p1 <= '0;
        rep    <= 2'd0;
      end
    end
  end

  assign bg_r      = pix_p1.r;
  assign bg_g      = pix_p1.g;
  assign bg_b      = pix_p1.b;
  assign bg_a      = pix_p1.a;
  assign underflow = underflow_r;

endmodule

// File: tb/tb_overlay_prefetch.sv
// Scoreboard bench for overlay_prefetch: an SDRAM model answers reads with
// data equal to the address; a frame-level model predicts the pixel stream.
module tb_overlay_prefetch;

  localparam int ADDR_W = 25;
  localparam int DEPTH  = 16;
  localparam int PIX_W  = 16;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic              reset, enable, ce_pix, de, vsync;
  logic [ADDR_W-1:0] base_addr;
  logic [1:0]        hscale;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd, mem_ack;
  logic [PIX_W-1:0]  mem_data;
  logic [3:0]        bg_r, bg_g, bg_b, bg_a;
  logic              underflow;

  overlay_prefetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PIX_W(PIX_W)) dut (
    .clk_sys(clk_sys), .reset(reset), .enable(enable), .base_addr(base_addr),
    .hscale(hscale), .ce_pix(ce_pix), .de(de), .vsync(vsync),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ack(mem_ack), .mem_data(mem_data),
    .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b), .bg_a(bg_a), .underflow(underflow)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- SDRAM model ----------------
  int                lat = 3;
  bit                pending = 1'b0;
  int                pend_cnt = 0;
  logic [ADDR_W-1:0] pend_addr = '0;
  logic [ADDR_W-1:0] req_q[$];

  initial begin
    mem_ack  = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge clk_sys);
      if (mem_rd === 1'b1) begin
        check("single_outstanding", 32'(pending), 32'd0);
        pending   = 1'b1;
        pend_cnt  = lat;
        pend_addr = mem_addr;
        req_q.push_back(mem_addr);
      end
      @(posedge clk_sys);
      #1;
      mem_ack = 1'b0;
      if (pending) begin
        pend_cnt--;
        if (pend_cnt <= 0) begin
          mem_ack  = 1'b1;
          mem_data = pend_addr[15:0];
          pending  = 1'b0;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:0] pix;
    bit          cp;
    bit          uf;
    bit          cu;
  } exp_t;
  exp_t exp_q[$];

  initial begin
    bit   cons_prev;
    exp_t e;
    cons_prev = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (cons_prev) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_pixel", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (e.cp) check("pixel", 32'({bg_a, bg_b, bg_g, bg_r}), 32'(e.pix));
          if (e.cu) check("underflow_flag", 32'(underflow), 32'(e.uf));
        end
      end
      cons_prev = (ce_pix === 1'b1) && (de === 1'b1) && (enable === 1'b1) && (reset === 1'b0);
      if (dut.fifo_push === 1'b1)
        check("no_push_when_full", 32'(dut.fifo_count < (DEPTH)), 32'd1);
    end
  end

  // ---------------- reference model ----------------
  logic [ADDR_W-1:0] m_base = '0;
  int                m_nw = 0;
  int                m_rep = 0;

  function automatic int scale_of(input logic [1:0] h);
    if (h == 2'd1) return 2;
    if (h == 2'd2) return 4;
    return 1;
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic exp_next();
    logic [ADDR_W-1:0] a;
    exp_t e;
    a = m_base + ADDR_W'(2 * m_nw);
    e.pix = a[15:0];
    e.cp = 1'b1; e.uf = 1'b0; e.cu = 1'b1;
    exp_q.push_back(e);
    m_rep++;
    if (m_rep >= scale_of(hscale)) begin
      m_rep = 0;
      m_nw++;
    end
  endtask

  task automatic pix_raw(input bit d, input int gap);
    ce_pix = 1'b1;
    de     = d;
    tick();
    ce_pix = 1'b0;
    de     = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic pix_de(input int gap);
    exp_next();
    pix_raw(1'b1, gap);
  endtask

  task automatic line_end(input int gap);
    m_rep = 0;
    pix_raw(1'b0, gap);
  endtask

  task automatic frame_start(input logic [ADDR_W-1:0] b, input logic [1:0] h);
    base_addr = b;
    hscale    = h;
    vsync     = 1'b1;
    ce_pix    = 1'b1;
    de        = 1'b0;
    tick();
    req_q.delete();
    ce_pix = 1'b0;
    m_base = b;
    m_nw   = 0;
    m_rep  = 0;
    tick();
    vsync = 1'b0;
    pix_raw(1'b0, 2);
  endtask

  task automatic wait_pending();
    int k;
    k = 0;
    while (!pending && k < 60) begin
      tick();
      k++;
    end
    check("request_issued", 32'(pending), 32'd1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      tick();
      k++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    exp_t e;
    int   n;
    reset = 1'b1; enable = 1'b0; base_addr = '0; hscale = 2'd0;
    ce_pix = 1'b0; de = 1'b0; vsync = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_bg", 32'({bg_a, bg_b, bg_g, bg_r}), 32'd0);
    check("reset_underflow", 32'(underflow), 32'd0);
    check("reset_mem_rd", 32'(mem_rd), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);

    // Fill from base 0x100: 16 sequential reads then stop.
    frame_start(25'h100, 2'd0);
    req_q.delete();
    enable = 1'b1;
    repeat (300) tick();
    check("fill_req_count", 32'(req_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < req_q.size(); i++)
      check("fill_req_addr", 32'(req_q[i]), 32'(25'h100 + 25'(2 * i)));
    repeat (50) tick();
    check("fill_req_stop", 32'(req_q.size()), 32'd16);

    // 1x line of 8 pixels, then a 2x line of 6 and another 2x line of 4.
    for (int i = 0; i < 8; i++) pix_de(4);
    line_end(4);
    hscale = 2'd1;
    for (int i = 0; i < 6; i++) pix_de(4);
    line_end(4);
    for (int i = 0; i < 4; i++) pix_de(4);
    line_end(4);
    drain();

    // Starvation: slow SDRAM and fast pixels drain the FIFO.
    frame_start(25'h4000, 2'd0);
    repeat (300) tick();
    lat = 40;
    for (int i = 0; i < 16; i++) pix_de(2);
    for (int i = 16; i < 30; i++) begin
      e.pix = 16'h0; e.cp = (i == 16); e.uf = 1'b1; e.cu = 1'b1;
      exp_q.push_back(e);
      pix_raw(1'b1, 2);
    end
    drain();
    lat = 3;
    frame_start(25'h4000, 2'd0);
    check("underflow_cleared", 32'(underflow), 32'd0);
    repeat (300) tick();

    // Frame start while a read is outstanding: its data must be dropped.
    lat = 30;
    pix_de(1);
    wait_pending();
    frame_start(25'h2000, 2'd0);
    lat = 3;
    repeat (400) tick();
    check("vs_req_count", 32'(req_q.size()), 32'd16);
    if (req_q.size() > 0) check("vs_first_addr", 32'(req_q[0]), 32'h2000);
    for (int i = 0; i < 10; i++) pix_de(4);
    line_end(4);
    drain();

    // Randomised frames, including one whose addresses wrap.
    for (int f = 0; f < 4; f++) begin
      logic [ADDR_W-1:0] b;
      b = (f == 2) ? 25'h1FFFFF0 : ADDR_W'($urandom_range(0, 32'h00FF_FFFF) & 32'hFFFF_FFFE);
      lat = $urandom_range(1, 4);
      frame_start(b, 2'($urandom_range(0, 3)));
      repeat (300) tick();
      for (int l = 0; l < 5; l++) begin
        n = $urandom_range(1, 20);
        for (int p = 0; p < n; p++) pix_de($urandom_range(8, 11));
        line_end(8);
      end
      drain();
    end

    // Disable mid-frame with a read pending.
    lat = 20;
    frame_start(25'h600, 2'd0);
    repeat (400) tick();
    pix_de(1);
    wait_pending();
    enable = 1'b0;
    tick();
    check("disable_bg", 32'({bg_a, bg_b, bg_g, bg_r}), 32'd0);
    n = req_q.size();
    repeat (100) tick();
    check("disable_no_req", 32'(req_q.size()), 32'(n));
    check("disable_mem_rd", 32'(mem_rd), 32'd0);

    // Reset while waiting for an ack; the late ack must not disturb anything.
    enable = 1'b1;
    lat = 20;
    frame_start(25'h800, 2'd0);
    repeat (400) tick();
    pix_de(1);
    wait_pending();
    reset  = 1'b1;
    enable = 1'b0;
    tick();
    reset = 1'b0;
    check("rst_wait_bg", 32'({bg_a, bg_b, bg_g, bg_r}), 32'd0);
    check("rst_wait_underflow", 32'(underflow), 32'd0);
    check("rst_wait_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_wait_mem_addr", 32'(mem_addr), 32'd0);
    repeat (40) tick();
    check("rst_late_ack_no_req", 32'(mem_rd), 32'd0);
    lat = 3;
    frame_start(25'hA00, 2'd0);
    req_q.delete();
    enable = 1'b1;
    repeat (300) tick();
    if (req_q.size() > 0) check("rst_first_addr", 32'(req_q[0]), 32'hA00);
    else check("rst_first_addr_present", 32'd0, 32'd1);
    for (int i = 0; i < 8; i++) pix_de(4);
    line_end(4);
    drain();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
